// File: rtl/pwm_capture.sv
// PWM receiver: measures period and high time (clk cycles, rise to rise) of an async input.
// Results are registered and appear SYNC_STAGES edges after pwm_in is first sampled high; there is no backpressure.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cap_en,
  input  logic             ovf_clr,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_meas,
  output logic [CNT_W-1:0] high_meas,
  output logic             meas_valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       high_lat;

  logic s, rise, fall, cnt_max;
  logic [CNT_W-1:0] cnt_inc;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign cnt_max = (cnt == {CNT_W{1'b1}});
  // A fall on the very last count saturates rather than wraps; LOW then overflows.
  assign cnt_inc = cnt_max ? cnt : cnt + CNT_W'(1);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d    <= s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      high_lat    <= '0;
      period_meas <= '0;
      high_meas   <= '0;
      meas_valid  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      // Overflow set further down is a later assignment, so set beats clear.
      if (ovf_clr) overflow <= 1'b0;
      if (!cap_en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if (rise) begin
              cnt   <= CNT_W'(1);
              state <= HIGH;
            end
          end
          HIGH: begin
            if (fall) begin
              high_lat <= cnt;
              cnt      <= cnt_inc;
              state    <= LOW;
            end else if (cnt_max) begin
              overflow <= 1'b1;
              cnt      <= '0;
              state    <= ARM;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          LOW: begin
            if (rise) begin
              period_meas <= cnt;
              high_meas   <= high_lat;
              meas_valid  <= 1'b1;
              cnt         <= CNT_W'(1);
              state       <= HIGH;
            end else if (cnt_max) begin
              overflow <= 1'b1;
              cnt      <= '0;
              state    <= ARM;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            cnt   <= '0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture, run with an 8-bit counter so saturation is reachable.
module tb_pwm_capture;

  localparam int CW         = 8;
  localparam int GEN_PERIOD = 20;
  localparam int GEN_CMP    = 7;

  typedef struct packed {
    logic [CW-1:0] per;
    logic [CW-1:0] hi;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n, cap_en, ovf_clr, pwm_in;
  logic [CW-1:0] period_meas, high_meas;
  logic          meas_valid, overflow, busy;

  logic pwm_drv;
  logic gen_en;
  int   gen_cnt;
  int   gen_pushes;
  int   total = 0;
  int   bad   = 0;
  int   vcount = 0;
  exp_t sb[$];

  pwm_capture #(.CNT_W(CW), .SYNC_STAGES(2)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cap_en      (cap_en),
    .ovf_clr     (ovf_clr),
    .pwm_in      (pwm_in),
    .period_meas (period_meas),
    .high_meas   (high_meas),
    .meas_valid  (meas_valid),
    .overflow    (overflow),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference PWM generator: period GEN_PERIOD, high for counts below GEN_CMP.
  assign pwm_in = gen_en ? (gen_cnt < GEN_CMP) : pwm_drv;

  always @(posedge clk) begin
    if (!gen_en) begin
      gen_cnt <= 0;
    end else begin
      gen_cnt <= (gen_cnt == GEN_PERIOD - 1) ? 0 : gen_cnt + 1;
      if (gen_cnt == GEN_PERIOD - 1 && gen_pushes < 3) begin
        exp_t e;
        e.per = CW'(GEN_PERIOD);
        e.hi  = CW'(GEN_CMP);
        sb.push_back(e);
        gen_pushes++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && meas_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexp_valid", {31'd0, meas_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("period", {24'd0, period_meas}, {24'd0, e.per});
        check("high", {24'd0, high_meas}, {24'd0, e.hi});
      end
      vcount++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int h, input int l, input bit rec);
    if (rec) begin
      exp_t e;
      e.per = CW'(h + l);
      e.hi  = CW'(h);
      sb.push_back(e);
    end
    pwm_drv = 1'b1;
    repeat (h) tick();
    pwm_drv = 1'b0;
    repeat (l) tick();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    check("q_drain", sb.size(), 0);
  endtask

  initial begin
    int hits;
    int base;
    rst_n = 1'b0; cap_en = 1'b0; ovf_clr = 1'b0; pwm_drv = 1'b0;
    gen_en = 1'b0; gen_pushes = 0;
    #1;
    check("rst_period", period_meas, 0);
    check("rst_high", high_meas, 0);
    check("rst_valid", meas_valid, 0);
    check("rst_ovf", overflow, 0);
    check("rst_busy", busy, 0);

    repeat (2) tick();
    rst_n = 1'b1; cap_en = 1'b1;
    repeat (2) tick();
    check("busy_arm", busy, 1);
    repeat (3) tick();

    // Steady 3/5, then duty change to 6/2 without re-arming.
    repeat (4) pulse(3, 5, 1'b1);
    pulse(3, 5, 1'b1);
    pulse(6, 2, 1'b1);
    pulse(6, 2, 1'b1);

    // Rise delivers the last 8/6, then cap_en drops mid-LOW.
    pwm_drv = 1'b1;
    repeat (4) tick();
    pwm_drv = 1'b0;
    repeat (3) tick();
    wait_drain();
    cap_en = 1'b0;
    tick();
    check("busy_drop", busy, 0);
    cap_en = 1'b1;
    tick();
    check("busy_rearm", busy, 1);
    check("hold_period", period_meas, 8);
    check("hold_high", high_meas, 6);
    repeat (3) tick();
    pulse(5, 5, 1'b1);
    pulse(5, 5, 1'b1);

    // Async reset mid-HIGH.
    pwm_drv = 1'b1;
    repeat (5) tick();
    wait_drain();
    #2 rst_n = 1'b0;
    #1;
    check("arst_period", period_meas, 0);
    check("arst_high", high_meas, 0);
    check("arst_ovf", overflow, 0);
    check("arst_busy", busy, 0);
    pwm_drv = 1'b0;
    repeat (4) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    pulse(4, 6, 1'b1);

    // Held high: HIGH saturates at 255 and overflows.
    pwm_drv = 1'b1;
    repeat (4) tick();
    wait_drain();
    for (int i = 0; i < 400 && overflow !== 1'b1; i++) tick();
    check("ovf_set", overflow, 1);
    check("ovf_hold_period", period_meas, 10);
    check("ovf_hold_high", high_meas, 4);
    check("ovf_busy_arm", busy, 1);
    cap_en = 1'b0;
    tick();
    cap_en = 1'b1;
    tick();
    check("ovf_sticky_en", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // ovf_clr held through a second overflow: set must win for exactly that cycle.
    pwm_drv = 1'b0;
    repeat (5) tick();
    ovf_clr = 1'b1;
    pwm_drv = 1'b1;
    hits = 0;
    repeat (320) begin
      tick();
      if (overflow === 1'b1) hits++;
    end
    ovf_clr = 1'b0;
    check("ovf_set_wins", hits, 1);

    // Loopback against the reference generator.
    pwm_drv = 1'b0;
    repeat (5) tick();
    base = vcount;
    gen_en = 1'b1;
    for (int i = 0; i < 200 && vcount < base + 3; i++) tick();
    check("loop_strobes", vcount - base, 3);
    cap_en = 1'b0;
    gen_en = 1'b0;
    repeat (3) tick();
    check("end_busy", busy, 0);
    check("end_q", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
